// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared state type and index widths for vector_mul_sequencer
// Purpose: FSM state enum, default index widths and the width helper used by
//          the sequencer, its interface and the bench.
// Ports:   none (package)
package vm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    EMIT,
    FIN
  } vm_state_e;

  // Index width for a counter covering 0..n-1; a single-entry dimension still
  // gets a 1-bit index so no port collapses to zero width.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int FEATURE_ROWS_DEF = 6;
  localparam int FEATURE_COLS_DEF = 96;
  localparam int WEIGHT_COLS_DEF  = 3;

  localparam int ROW_W = idx_w(FEATURE_ROWS_DEF);
  localparam int K_W   = idx_w(FEATURE_COLS_DEF);
  localparam int COL_W = idx_w(WEIGHT_COLS_DEF);

endpackage

// File: rtl/vector_mul_sequencer_if.sv
// rtl/vector_mul_sequencer_if.sv - control/address/handshake bundle of the sequencer
// Purpose: groups start/busy/done, memory read addresses, MAC strobes and the
//          output element handshake.
// Ports:   master = sequencer side (drives everything except start/out_ready),
//          slave  = environment side (drives start and out_ready).
interface vector_mul_sequencer_if #(
  parameter int ROW_W = vm_pkg::ROW_W,
  parameter int K_W   = vm_pkg::K_W,
  parameter int COL_W = vm_pkg::COL_W
) ();

  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [ROW_W-1:0] feat_row;
  logic [K_W-1:0]   feat_col;
  logic [K_W-1:0]   wgt_row;
  logic [COL_W-1:0] wgt_col;
  logic             mac_clear;
  logic             mac_en;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;

  modport master (
    input  start, out_ready,
    output busy, done, rd_en, feat_row, feat_col, wgt_row, wgt_col,
           mac_clear, mac_en, out_valid, out_row, out_col
  );

  modport slave (
    output start, out_ready,
    input  busy, done, rd_en, feat_row, feat_col, wgt_row, wgt_col,
           mac_clear, mac_en, out_valid, out_row, out_col
  );

endinterface

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-MAX index counter with terminal flag
// Purpose: counts 0..MAX-1 and wraps to 0; MAX need not be a power of two.
// Ports:   clk, rst_n (async active-low), clr (sync clear, wins over inc),
//          inc (advance), cnt (current value), last (cnt == MAX-1).
module wrap_counter #(
  parameter int MAX = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == W'(MAX - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vector_mul_sequencer.sv
// rtl/vector_mul_sequencer.sv - control FSM sequencing the MAC datapath for one matrix product
// Purpose: walks out[r][c] = sum_k features[r][k] * weights[k][c], issuing reads,
//          MAC clear/enable strobes and an output handshake per element.
// Ports:   clk, rst_n (async active-low), bus (vector_mul_sequencer_if.master):
//          start/busy/done, rd_en + feat/wgt addresses, mac_clear/mac_en,
//          out_valid/out_ready + out_row/out_col.
module vector_mul_sequencer
  import vm_pkg::*;
#(
  parameter int FEATURE_ROWS = 6,
  parameter int FEATURE_COLS = 96,
  parameter int WEIGHT_COLS  = 3,
  parameter int RD_LATENCY   = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  vector_mul_sequencer_if.master bus
);

  localparam int RW = idx_w(FEATURE_ROWS);
  localparam int KW = idx_w(FEATURE_COLS);
  localparam int CW = idx_w(WEIGHT_COLS);

  vm_state_e state_q, state_d;

  logic [KW-1:0] k;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic          k_last, c_last, r_last;

  logic accept;
  logic run;
  logic handshake;

  assign accept    = (state_q == IDLE) && bus.start;
  assign run       = (state_q == RUN);
  assign handshake = (state_q == EMIT) && bus.out_ready;

  // k wraps to 0 on its own at the end of RUN, so the next element restarts
  // at k=0 without an explicit clear.
  wrap_counter #(.MAX(FEATURE_COLS), .W(KW)) u_k (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .inc  (run),
    .cnt  (k),
    .last (k_last)
  );

  wrap_counter #(.MAX(WEIGHT_COLS), .W(CW)) u_c (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .inc  (handshake),
    .cnt  (c),
    .last (c_last)
  );

  wrap_counter #(.MAX(FEATURE_ROWS), .W(RW)) u_r (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .inc  (handshake && c_last),
    .cnt  (r),
    .last (r_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (k_last) state_d = DRAIN;
      DRAIN:   state_d = EMIT;
      EMIT:    if (bus.out_ready) state_d = (r_last && c_last) ? FIN : RUN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read strobe and "first k of element" travel down matched delay lines so
  // mac_en/mac_clear line up with the data returning from the memories.
  // DRAIN is a single cycle, which matches the one-cycle read latency.
  logic [RD_LATENCY-1:0] en_sr_q;
  logic [RD_LATENCY-1:0] clr_sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sr_q  <= '0;
      clr_sr_q <= '0;
    end else begin
      en_sr_q[0]  <= run;
      clr_sr_q[0] <= run && (k == '0);
      for (int i = 1; i < RD_LATENCY; i++) begin
        en_sr_q[i]  <= en_sr_q[i-1];
        clr_sr_q[i] <= clr_sr_q[i-1];
      end
    end
  end

  assign bus.busy      = (state_q == RUN) || (state_q == DRAIN) || (state_q == EMIT);
  assign bus.done      = (state_q == FIN);
  assign bus.rd_en     = run;
  assign bus.feat_row  = r;
  assign bus.feat_col  = k;
  assign bus.wgt_row   = k;
  assign bus.wgt_col   = c;
  assign bus.mac_en    = en_sr_q[RD_LATENCY-1];
  assign bus.mac_clear = clr_sr_q[RD_LATENCY-1];
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_row   = r;
  assign bus.out_col   = c;

endmodule
